abus_master_arbiter: RTL and testbench

//   Round-robin arbiter sharing one abus_master port between N_REQ requesters.
//   It latches a requester's command, drives it to the master and waits for

---
 rtl/abus_master_arbiter.sv | 163 ++++++++++++++++
 tb/tb_abus_master_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abus_master_arbiter.sv
// Round-robin arbiter sharing a single abus_master port between N_REQ clients.
// Latches the winner's command, waits for completion or timeout, pulses status.
module abus_master_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                        abus_clk,
  input  logic                        abus_rst,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [N_REQ-1:0]            req_read,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_address,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            req_grant,
  output logic [N_REQ-1:0]            req_done,
  output logic [N_REQ-1:0]            req_err,
  output logic [DATA_WIDTH-1:0]       req_rdata,
  output logic                        m_write,
  output logic                        m_read,
  output logic [ADDR_WIDTH-1:0]       m_address,
  output logic [DATA_WIDTH-1:0]       m_wdata,
  input  logic                        m_done,
  input  logic                        m_new_rdata,
  input  logic                        m_err,
  input  logic [DATA_WIDTH-1:0]       m_rdata
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state, state_nx;
  logic [IW-1:0]         rr, rr_nx;
  logic [IW-1:0]         owner, owner_nx;
  logic                  op_wr, op_wr_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [N_REQ-1:0]      grant_nx, done_nx, err_nx;
  logic [DATA_WIDTH-1:0] rdata_nx;
  logic                  mw_nx, mr_nx;
  logic [ADDR_WIDTH-1:0] maddr_nx;
  logic [DATA_WIDTH-1:0] mwdata_nx;

  logic [N_REQ-1:0] pend;
  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    cand;
  logic [N_REQ-1:0] win_oh;
  logic             op_ok;
  logic             to_hit;

  assign pend   = req_write | req_read;
  assign op_ok  = op_wr ? m_done : m_new_rdata;
  assign to_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  // Scan farthest offset first so the nearest pending index after rr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = IW'((int'(rr) + off) % N_REQ);
      if (pend[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

  always_comb begin
    state_nx  = state;
    rr_nx     = rr;
    owner_nx  = owner;
    op_wr_nx  = op_wr;
    cnt_nx    = cnt;
    grant_nx  = req_grant;
    done_nx   = '0;
    err_nx    = '0;
    rdata_nx  = req_rdata;
    mw_nx     = m_write;
    mr_nx     = m_read;
    maddr_nx  = m_address;
    mwdata_nx = m_wdata;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          grant_nx = win_oh;
          owner_nx = win_idx;
          if (req_write[win_idx] && req_read[win_idx]) begin
            err_nx   = win_oh;
            state_nx = DONE;
          end else begin
            mw_nx     = req_write[win_idx];
            mr_nx     = req_read[win_idx];
            op_wr_nx  = req_write[win_idx];
            maddr_nx  = req_address[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            mwdata_nx = req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            cnt_nx    = '0;
            state_nx  = BUSY;
          end
        end
      end
      BUSY: begin
        if (m_err || op_ok || to_hit) begin
          mw_nx    = 1'b0;
          mr_nx    = 1'b0;
          state_nx = DONE;
          if (!m_err && op_ok) begin
            done_nx = req_grant;
            if (!op_wr) rdata_nx = m_rdata;
          end else begin
            err_nx = req_grant;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DONE: begin
        grant_nx = '0;
        rr_nx    = owner;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge abus_clk or posedge abus_rst) begin
    if (abus_rst) begin
      state     <= IDLE;
      rr        <= IW'(N_REQ - 1);
      owner     <= '0;
      op_wr     <= 1'b0;
      cnt       <= '0;
      req_grant <= '0;
      req_done  <= '0;
      req_err   <= '0;
      req_rdata <= '0;
      m_write   <= 1'b0;
      m_read    <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
    end else begin
      state     <= state_nx;
      rr        <= rr_nx;
      owner     <= owner_nx;
      op_wr     <= op_wr_nx;
      cnt       <= cnt_nx;
      req_grant <= grant_nx;
      req_done  <= done_nx;
      req_err   <= err_nx;
      req_rdata <= rdata_nx;
      m_write   <= mw_nx;
      m_read    <= mr_nx;
      m_address <= maddr_nx;
      m_wdata   <= mwdata_nx;
    end
  end

endmodule

// File: tb/tb_abus_master_arbiter.sv
// Bench for abus_master_arbiter: scripted requesters, slave model,
// status pulses checked against a queue of expected responses.
module tb_abus_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            abus_clk = 1'b0;
  logic            abus_rst = 1'b1;
  logic [N-1:0]    req_write = '0;
  logic [N-1:0]    req_read = '0;
  logic [N*AW-1:0] req_address = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_grant;
  logic [N-1:0]    req_done;
  logic [N-1:0]    req_err;
  logic [DW-1:0]   req_rdata;
  logic            m_write;
  logic            m_read;
  logic [AW-1:0]   m_address;
  logic [DW-1:0]   m_wdata;
  logic            m_done = 1'b0;
  logic            m_new_rdata = 1'b0;
  logic            m_err = 1'b0;
  logic [DW-1:0]   m_rdata = '0;

  abus_master_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)
  ) dut (
    .abus_clk(abus_clk), .abus_rst(abus_rst),
    .req_write(req_write), .req_read(req_read),
    .req_address(req_address), .req_wdata(req_wdata),
    .req_grant(req_grant), .req_done(req_done), .req_err(req_err),
    .req_rdata(req_rdata),
    .m_write(m_write), .m_read(m_read),
    .m_address(m_address), .m_wdata(m_wdata),
    .m_done(m_done), .m_new_rdata(m_new_rdata), .m_err(m_err),
    .m_rdata(m_rdata)
  );

  always #5 abus_clk = ~abus_clk;

  typedef struct {
    logic [N-1:0]  done;
    logic [N-1:0]  err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sbq[$];
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] model_rdata = '0;
  int            rem[N];

  // slave model config and observations
  int            sl_lat = 1;
  int            sl_mode = 0;
  logic [DW-1:0] sl_rdata = '0;
  int            hi_cnt = 0;
  logic [AW-1:0] cap_addr = '0;
  logic [DW-1:0] cap_wdata = '0;
  logic [N-1:0]  cap_grant = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] d, input logic [N-1:0] e);
    exp_t x;
    x.done  = d;
    x.err   = e;
    x.rdata = model_rdata;
    sbq.push_back(x);
  endtask

  task automatic issue(input int r, input bit wr, input bit rd,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int n);
    req_write[r] = wr;
    req_read[r]  = rd;
    req_address[r*AW +: AW] = a;
    req_wdata[r*DW +: DW]   = d;
    rem[r] = n;
  endtask

  // Mode 0: normal answer after sl_lat cycles; 1: silent; 2: m_err+m_done.
  task automatic slave_loop();
    int c = 0;
    forever begin
      @(negedge abus_clk);
      if (m_write || m_read) begin
        c++;
        hi_cnt++;
        if (c == 1) begin
          cap_addr  = m_address;
          cap_wdata = m_wdata;
          cap_grant = req_grant;
        end
        if (c == sl_lat && sl_mode != 1) begin
          if (sl_mode == 2) begin
            m_err  = 1'b1;
            m_done = 1'b1;
          end else if (m_write) begin
            m_done = 1'b1;
          end else begin
            m_new_rdata = 1'b1;
            m_rdata     = sl_rdata;
          end
        end
      end else begin
        c = 0;
        m_done      = 1'b0;
        m_err       = 1'b0;
        m_new_rdata = 1'b0;
      end
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge abus_clk);
      if (!abus_rst && (req_done != '0 || req_err != '0)) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: done=%b err=%b", req_done, req_err);
        end else begin
          e = sbq.pop_front();
          if (req_done !== e.done || req_err !== e.err ||
              req_rdata !== e.rdata) begin
            bad++;
            $display("FAIL status: got done=%b err=%b rdata=%h expected done=%b err=%b rdata=%h",
                     req_done, req_err, req_rdata, e.done, e.err, e.rdata);
          end
        end
      end
    end
  endtask

  // Requesters drop their op when status is seen; waits for full drain.
  task automatic serve(input string name);
    bit fin = 1'b0;
    for (int k = 0; k < 300 && !fin; k++) begin
      @(negedge abus_clk);
      for (int i = 0; i < N; i++) begin
        if (req_done[i] || req_err[i]) begin
          rem[i]--;
          if (rem[i] <= 0) begin
            req_write[i] = 1'b0;
            req_read[i]  = 1'b0;
          end
        end
      end
      if ((req_write | req_read) == '0 && req_grant == '0 && sbq.size() == 0)
        fin = 1'b1;
    end
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL %s_drain: pending=%0d expected 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic wait_op(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge abus_clk);
      if (m_write || m_read) ok = 1'b1;
    end
  endtask

  initial begin
    int h0;
    bit ok;
    for (int i = 0; i < N; i++) rem[i] = 0;
    fork
      slave_loop();
      monitor_loop();
    join_none

    repeat (2) @(negedge abus_clk);
    abus_rst = 1'b0;
    @(negedge abus_clk);
    chk("rst_grant", 32'(req_grant), 32'h0);
    chk("rst_mop", 32'({m_write, m_read}), 32'h0);
    chk("rst_pulses", 32'({req_done, req_err}), 32'h0);
    chk("rst_rdata", 32'(req_rdata), 32'h0);

    // all four requesting, two ops each: order 0,1,2,3,0,1,2,3
    sl_mode = 0;
    sl_lat  = 1;
    for (int i = 0; i < N; i++) issue(i, 1'b1, 1'b0, AW'(16'h100 + i), DW'(i), 2);
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < N; i++) push(N'(1 << i), '0);
    serve("fair");

    // single write by req0, answered after 3 cycles
    sl_lat = 3;
    h0 = hi_cnt;
    issue(0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 1);
    push(4'b0001, '0);
    serve("wr0");
    chk("wr0_hi_cycles", 32'(hi_cnt - h0), 32'd3);
    chk("wr0_addr", 32'(cap_addr), 32'h0010);
    chk("wr0_wdata", 32'(cap_wdata), 32'hBEEF);
    chk("wr0_grant", 32'(cap_grant), 32'h1);
    chk("wr0_mwrite_low", 32'(m_write), 32'h0);

    // read by req2 returning 0x1234
    sl_lat   = 2;
    sl_rdata = 16'h1234;
    h0 = hi_cnt;
    issue(2, 1'b0, 1'b1, 16'h0222, 16'h0, 1);
    model_rdata = 16'h1234;
    push(4'b0100, '0);
    serve("rd2");
    chk("rd2_hi_cycles", 32'(hi_cnt - h0), 32'd2);
    chk("rd2_addr", 32'(cap_addr), 32'h0222);
    chk("rd2_mread_low", 32'(m_read), 32'h0);

    // silent slave: timeout after 8 BUSY cycles
    sl_mode = 1;
    h0 = hi_cnt;
    issue(1, 1'b0, 1'b1, 16'h0333, 16'h0, 1);
    push('0, 4'b0010);
    serve("tmo");
    chk("tmo_hi_cycles", 32'(hi_cnt - h0), 32'd8);
    chk("tmo_mop_low", 32'({m_write, m_read}), 32'h0);

    // m_err with m_done on a write: error only, rdata kept
    sl_mode = 2;
    sl_lat  = 2;
    issue(3, 1'b1, 1'b0, 16'h0444, 16'h5555, 1);
    push('0, 4'b1000);
    serve("errdone");

    // illegal read+write: error without a bus access
    sl_mode = 0;
    h0 = hi_cnt;
    issue(1, 1'b1, 1'b1, 16'h0555, 16'h6666, 1);
    push('0, 4'b0010);
    serve("illegal");
    chk("illegal_no_bus", 32'(hi_cnt - h0), 32'd0);

    // reset in BUSY, then req1 and req0 together: req0 first
    sl_mode = 1;
    issue(2, 1'b1, 1'b0, 16'h0666, 16'h7777, 1);
    wait_op(ok);
    chk("midrst_busy_seen", 32'(ok), 32'h1);
    abus_rst = 1'b1;
    #1;
    chk("midrst_grant", 32'(req_grant), 32'h0);
    chk("midrst_mop", 32'({m_write, m_read}), 32'h0);
    chk("midrst_maddr", 32'(m_address), 32'h0);
    chk("midrst_rdata", 32'(req_rdata), 32'h0);
    req_write = '0;
    req_read  = '0;
    model_rdata = '0;
    @(negedge abus_clk);
    abus_rst = 1'b0;
    sl_mode  = 0;
    sl_lat   = 1;
    issue(1, 1'b1, 1'b0, 16'h0777, 16'h1111, 1);
    issue(0, 1'b1, 1'b0, 16'h0888, 16'h2222, 1);
    push(4'b0001, '0);
    push(4'b0010, '0);
    serve("postrst");

    repeat (3) @(negedge abus_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
